// File: rtl/probe_capture_pkg.sv
// Shared types and trigger-mode constants for the probe capture engine.
// Latency: none; declarations plus one combinational helper.
// Backpressure: not applicable.
package probe_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT,
        POST,
        DONE
    } cap_state_t;

    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;

    // Masked equality; callers zero-extend to 64 bits, which the widest probe bus fits.
    function automatic logic probe_match(input logic [63:0] probe,
                                         input logic [63:0] value,
                                         input logic [63:0] mask);
        return ((probe ^ value) & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Sample store: one write port, one registered read port, W x DEPTH, block-RAM shaped.
// Latency: read data appears one clock after the read address is sampled.
// Backpressure: none; a write or read is accepted every cycle.
module capture_ram #(
    parameter  int W     = 8,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Array itself is never reset so it maps onto a plain RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register carries the reset so the read port idles at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/probe_capture.sv
// Ring-buffer logic analyzer: pre-trigger window, maskable level/edge trigger, trigger-aligned readback.
// Latency: armed one cycle after arm, triggered one cycle after the trigger sample, reads one cycle.
// Backpressure: none; probes are sampled every cycle while a capture is in progress.
module probe_capture
    import probe_capture_pkg::*;
#(
    parameter  int PROBE_W = 8,
    parameter  int DEPTH   = 256,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PROBE_W-1:0] probe_i,
    input  logic               arm_i,
    input  logic               force_trig_i,
    input  logic               trig_edge_i,
    input  logic [PROBE_W-1:0] trig_mask_i,
    input  logic [PROBE_W-1:0] trig_value_i,
    input  logic [AW-1:0]      pretrig_i,
    input  logic [AW-1:0]      rd_addr_i,
    output logic [PROBE_W-1:0] rd_data_o,
    output logic               armed_o,
    output logic               triggered_o,
    output logic               done_o
);

    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    // Final post_cnt value is (DEPTH-2) - pretrig, giving DEPTH-1-pretrig post samples.
    localparam logic [AW-1:0] POST_BIAS = AW'(DEPTH - 2);

    cap_state_t    state;
    cap_state_t    state_nxt;
    logic [AW-1:0] wp;
    logic [AW-1:0] trig_ptr;
    logic [AW-1:0] pretrig_q;
    logic [AW-1:0] pre_cnt;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] rd_phys;
    logic          match;
    logic          match_prev;
    logic          hit;
    logic          trig;
    logic          capturing;
    logic          we;
    logic          triggered;

    assign match = probe_match(64'(probe_i), 64'(trig_value_i), 64'(trig_mask_i));

    // Next-state and per-cycle strobes; a concurrent arm overrides any trigger.
    always_comb begin
        state_nxt = state;
        capturing = (state == PRE) || (state == WAIT) || (state == POST);
        hit       = (trig_edge_i == TRIG_EDGE) ? (match & ~match_prev) : match;
        trig      = (state == WAIT) && !arm_i && (hit || force_trig_i);
        we        = capturing && !arm_i && !rst;
        if (arm_i) begin
            state_nxt = (pretrig_i == '0) ? WAIT : PRE;
        end else begin
            case (state)
                PRE:     if (pre_cnt == pretrig_q - ONE) state_nxt = WAIT;
                WAIT:    if (trig) state_nxt = (pretrig_q == LAST_IDX) ? DONE : POST;
                POST:    if (post_cnt == POST_BIAS - pretrig_q) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write pointer, window counters, trigger bookkeeping; wp free-runs across captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            trig_ptr   <= '0;
            pretrig_q  <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            match_prev <= 1'b0;
            triggered  <= 1'b0;
        end else begin
            // Seeding with 1 at arm keeps a match already present at arm from firing in edge mode.
            match_prev <= arm_i ? 1'b1 : match;
            if (we) begin
                wp <= wp + ONE;
            end
            if (arm_i) begin
                pretrig_q <= pretrig_i;
                pre_cnt   <= '0;
                post_cnt  <= '0;
                triggered <= 1'b0;
            end else begin
                if (state == PRE) begin
                    pre_cnt <= pre_cnt + ONE;
                end
                if (state == POST) begin
                    post_cnt <= post_cnt + ONE;
                end
                if (trig) begin
                    trig_ptr  <= wp;
                    triggered <= 1'b1;
                end
            end
        end
    end

    // Logical index 0 is the oldest sample, so the trigger lands at index pretrig.
    assign rd_phys = trig_ptr - pretrig_q + rd_addr_i;

    capture_ram #(
        .W     (PROBE_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wp),
        .wdata (probe_i),
        .raddr (rd_phys),
        .rdata (rd_data_o)
    );

    assign armed_o     = capturing;
    assign triggered_o = triggered;
    assign done_o      = (state == DONE);

endmodule

// File: doc/probe_capture.md
# probe_capture

Parametrised multi-channel capture engine, the successor to the single-signal analyzer core behind the JTAG control chain. It samples a `PROBE_W`-bit probe bus every `clk` into a `DEPTH`-entry ring buffer. Triggering is maskable, by level or rising-match edge, with a programmable pre-trigger window. The debug controller reads the captured window back through a linear, trigger-aligned read port.

## Interface
- `PROBE_W`, 8: probe bus width (1..64).
- `DEPTH`, 256: samples per capture; power of two, ≥4. `AW = log2(DEPTH)`.
- `clk`  in  1: sole clock; probes and control are synchronous to it.
- `rst`  in  1: synchronous, active-high reset.
- `probe_i`  in  PROBE_W: signals under observation.
- `arm_i`  in  1: one-cycle pulse; starts, or restarts, a capture.
- `force_trig_i`  in  1: trigger unconditionally while waiting for trigger.
- `trig_edge_i`  in  1: 0 = level match, 1 = rising edge of match.
- `trig_mask_i`  in  PROBE_W: 1 = bit participates in the match.
- `trig_value_i`  in  PROBE_W: compare value for masked bits.
- `pretrig_i`  in  AW: samples kept before the trigger sample; latched at arm.
- `rd_addr_i`  in  AW: logical sample index, 0 = oldest in window.
- `rd_data_o`  out  PROBE_W: sample at `rd_addr_i`; one-cycle latency.
- `armed_o`  out  1: capture in progress (PRE, WAIT, POST).
- `triggered_o`  out  1: trigger has occurred in the current capture.
- `done_o`  out  1: window complete and readable.

## Operation
- Match: `match = ((probe_i ^ trig_value_i) & trig_mask_i) == 0`. An all-zero mask makes `match` constant 1.
- Edge mode: `hit = match & ~match_prev`. `match_prev` is set to 1 at arm, so a match already present at arm does not fire; an all-zero mask therefore never fires in edge mode.
- Level mode: `hit = match`.
- Trigger = `hit | force_trig_i`, evaluated only in WAIT.
- States:
  - IDLE: nothing written.
  - PRE: write `probe_i` each cycle; `pre_cnt` counts to `pretrig`.
  - WAIT: write each cycle and evaluate the trigger.
  - POST: write each cycle; `post_cnt` counts `DEPTH-1-pretrig` samples.
  - DONE: hold.
- Transitions:
  - arm in any state → PRE, or WAIT if `pretrig=0`.
  - PRE → WAIT after `pretrig` writes.
  - WAIT → POST on trigger; the trigger sample is written in that same cycle and its address is latched as `trig_ptr`.
  - POST → DONE after the last post sample. If `pretrig=DEPTH-1`, the post count is 0 and the FSM goes WAIT → DONE directly.
- Write pointer `wp` (AW bits) increments per write and wraps modulo DEPTH. It is not reset at arm.
- Read mapping: physical address = `trig_ptr - pretrig + rd_addr_i` mod DEPTH. Logical index `pretrig` is always the trigger sample.
- While WAIT lasts longer than DEPTH cycles the ring overwrites itself. This is intended: the pre-window is the most recent `pretrig` samples.
- `arm_i` while armed aborts the current capture and restarts it, clearing `triggered_o`.
- `rst` in any state: FSM → IDLE, counters and `match_prev` cleared, outputs low. RAM contents are not cleared.

## Timing
- Reset values: `armed_o=0`, `triggered_o=0`, `done_o=0`, `rd_data_o=0`.
- arm sampled at cycle N: first write at N+1, and `armed_o` is high from N+1.
- Trigger at cycle T: `triggered_o` rises at T+1.
- Last post write at cycle L: `armed_o` falls and `done_o` rises at L+1. `done_o` holds until the next arm or `rst`.
- End-to-end: the capture spans exactly DEPTH writes from the first PRE write, provided the trigger arrives no earlier than the end of PRE.
- Read: `rd_data_o` reflects `rd_addr_i` from the previous cycle, any state. Contents are defined only while `done_o=1`.
- `arm_i` together with `rst`: `rst` wins.
- `arm_i` together with a trigger in WAIT: the arm wins and the trigger is discarded.

## Structure
- Package `probe_capture_pkg`:
  - state enum `cap_state_t` (IDLE, PRE, WAIT, POST, DONE);
  - trigger-mode constants `TRIG_LEVEL=0`, `TRIG_EDGE=1`.
- Sub-module `capture_ram`: simple dual-port RAM, one write port and one registered read port, `PROBE_W` × `DEPTH`, inferable as block RAM.
- All FSM, counter and address logic lives in `probe_capture`.

## Test plan
All scenarios use `PROBE_W=8`, `DEPTH=16`.
- Level trigger: `probe_i` counts up from 0x00, mask 0xFF, value 0x20, `pretrig=4`, arm. → Read indices 0..15 return 0x1C..0x2B; `triggered_o` rises 1 cycle after 0x20 is sampled.
- Edge mode: `probe_i[0]` held 1 at arm, mask 0x01, value 0x01. → No trigger. Drop bit 0 for 1 cycle, then raise it → trigger on the re-rise; index `pretrig` reads bit0=1.
- Force, all-zero mask, edge mode, `pretrig=0`: → never triggers until `force_trig_i` pulses. Index 0 is the force-cycle sample; `done_o` rises 16 cycles after the force cycle.
- `pretrig=15`, level mask 0: → trigger in the first WAIT cycle, no POST phase. `done_o` 17 cycles after arm; index 15 is the trigger sample.
- Re-arm mid-POST, then `rst` mid-WAIT: → `triggered_o` clears on the re-arm and capture restarts. After `rst` all outputs are 0 the next cycle and the FSM is IDLE.
- Wrap: trigger arrives 40 cycles after arm with `pretrig=4`. → Indices 0..3 hold the 4 samples immediately preceding the trigger.
